// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - two-requester round-robin arbiter with lock, fronting a shared ALU
// Accept edge -> registered issue cycle -> status captured -> one-hot response strobe.
module alu_arb #(
  parameter logic [3:0] IDLE_OP = 4'b1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_lock,
  input  logic [63:0] req_rsa,
  input  logic [63:0] req_rsb,
  input  logic [31:0] req_imm,
  input  logic [7:0]  req_alu_op,
  input  logic [7:0]  req_funct,
  input  logic [1:0]  req_c_in,
  output logic [31:0] alu_rsa,
  output logic [31:0] alu_rsb,
  output logic [15:0] alu_imm,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_funct,
  output logic        alu_c_in,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_stat,
  input  logic [3:0]  alu_stat_en,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_stat,
  output logic [3:0]  rsp_stat_en
);

  logic [31:0] r_alu_rsa;
  logic [31:0] r_alu_rsb;
  logic [15:0] r_alu_imm;
  logic [3:0]  r_alu_op;
  logic [3:0]  r_alu_funct;
  logic        r_alu_c_in;
  logic        r_iss_valid;
  logic        r_iss_owner;
  logic [1:0]  r_rsp_valid;
  logic [3:0]  r_rsp_stat;
  logic [3:0]  r_rsp_stat_en;
  logic        r_locked;
  logic        r_lock_owner;
  logic        r_last_grant;

  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_sel;

  // Locked: only the owner may be granted. Unlocked tie: the requester not granted last wins.
  always_comb begin
    w_grant = 2'b00;
    if (rst) begin
      w_grant = 2'b00;
    end else if (r_locked) begin
      w_grant = r_lock_owner ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]};
    end else if (&req_valid) begin
      w_grant = r_last_grant ? 2'b01 : 2'b10;
    end else begin
      w_grant = req_valid;
    end
  end

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;
  assign w_sel     = w_grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_rsa     <= 32'd0;
      r_alu_rsb     <= 32'd0;
      r_alu_imm     <= 16'd0;
      r_alu_op      <= IDLE_OP;
      r_alu_funct   <= 4'd0;
      r_alu_c_in    <= 1'b0;
      r_iss_valid   <= 1'b0;
      r_iss_owner   <= 1'b0;
      r_rsp_valid   <= 2'b00;
      r_rsp_stat    <= 4'd0;
      r_rsp_stat_en <= 4'd0;
      r_locked      <= 1'b0;
      r_lock_owner  <= 1'b0;
      r_last_grant  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_alu_rsa    <= w_sel ? req_rsa[63:32]    : req_rsa[31:0];
        r_alu_rsb    <= w_sel ? req_rsb[63:32]    : req_rsb[31:0];
        r_alu_imm    <= w_sel ? req_imm[31:16]    : req_imm[15:0];
        r_alu_op     <= w_sel ? req_alu_op[7:4]   : req_alu_op[3:0];
        r_alu_funct  <= w_sel ? req_funct[7:4]    : req_funct[3:0];
        r_alu_c_in   <= w_sel ? req_c_in[1]       : req_c_in[0];
        r_iss_valid  <= 1'b1;
        r_iss_owner  <= w_sel;
        r_last_grant <= w_sel;
        r_locked     <= w_sel ? req_lock[1] : req_lock[0];
        r_lock_owner <= w_sel;
      end else begin
        // Idle issue: operands stay put so the ALU inputs do not toggle.
        r_alu_op    <= IDLE_OP;
        r_alu_funct <= 4'd0;
        r_iss_valid <= 1'b0;
      end
      r_rsp_valid <= r_iss_valid ? (r_iss_owner ? 2'b10 : 2'b01) : 2'b00;
      if (r_iss_valid) begin
        r_rsp_stat    <= alu_stat;
        r_rsp_stat_en <= alu_stat_en;
      end
    end
  end

  assign alu_rsa     = r_alu_rsa;
  assign alu_rsb     = r_alu_rsb;
  assign alu_imm     = r_alu_imm;
  assign alu_op      = r_alu_op;
  assign alu_funct   = r_alu_funct;
  assign alu_c_in    = r_alu_c_in;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = alu_result;
  assign rsp_stat    = r_rsp_stat;
  assign rsp_stat_en = r_rsp_stat_en;

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - scoreboard bench for alu_arb with a behavioural shared ALU
module tb_alu_arb;
  localparam logic [3:0] IDLE   = 4'b1100;
  localparam logic [3:0] OP_S   = 4'b0001;
  localparam logic [3:0] OP_N   = 4'b0010;
  localparam logic [3:0] FN_ADD = 4'd1;
  localparam logic [3:0] FN_SUB = 4'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_lock, req_c_in;
  logic [63:0] req_rsa, req_rsb;
  logic [31:0] req_imm;
  logic [7:0]  req_alu_op, req_funct;
  logic [31:0] alu_rsa, alu_rsb, alu_result;
  logic [15:0] alu_imm;
  logic [3:0]  alu_op, alu_funct, alu_stat, alu_stat_en;
  logic        alu_c_in;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_stat, rsp_stat_en;

  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] r;
    logic [3:0]  s;
    logic [3:0]  e;
  } rsp_t;
  rsp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  alu_arb #(.IDLE_OP(IDLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_rsa(req_rsa), .req_rsb(req_rsb), .req_imm(req_imm),
    .req_alu_op(req_alu_op), .req_funct(req_funct), .req_c_in(req_c_in),
    .alu_rsa(alu_rsa), .alu_rsb(alu_rsb), .alu_imm(alu_imm),
    .alu_op(alu_op), .alu_funct(alu_funct), .alu_c_in(alu_c_in),
    .alu_result(alu_result), .alu_stat(alu_stat), .alu_stat_en(alu_stat_en),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_stat(rsp_stat), .rsp_stat_en(rsp_stat_en)
  );

  always #5 clk = ~clk;

  // Returns {stat_en, stat, result}; stat = {C, N, V, Z}, enabled by op[0].
  function automatic logic [39:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic [3:0] fn, input logic ci);
    logic [32:0] sum;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; sum = 33'd0;
    if (op == IDLE) return {8'h00, a};
    case (fn)
      FN_ADD: begin
        sum = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        r = sum[31:0]; c = sum[32]; v = ~(a[31] ^ b[31]) & (a[31] ^ r[31]);
      end
      FN_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = sum[31:0]; c = sum[32]; v = (a[31] ^ b[31]) & (a[31] ^ r[31]);
      end
      default: r = a & b;
    endcase
    if (op[0]) return {4'hF, c, r[31], v, (r == 32'd0), r};
    return {8'h00, r};
  endfunction

  logic [39:0] w_alu;
  always_comb w_alu = alu_ref(alu_rsa, alu_rsb, alu_op, alu_funct, alu_c_in);
  assign alu_stat    = w_alu[35:32];
  assign alu_stat_en = w_alu[39:36];
  always @(posedge clk) alu_result <= w_alu[31:0];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clr_reqs();
    req_valid = 2'b00; req_lock = 2'b00; req_c_in = 2'b00;
    req_rsa = 64'd0; req_rsb = 64'd0; req_imm = 32'd0;
    req_alu_op = 8'd0; req_funct = 8'd0;
  endtask

  task automatic drive(input int i, input logic lk, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [3:0] fn, input logic ci);
    req_valid[i] = 1'b1; req_lock[i] = lk; req_c_in[i] = ci;
    req_rsa[32*i +: 32] = a; req_rsb[32*i +: 32] = b; req_imm[16*i +: 16] = a[15:0];
    req_alu_op[4*i +: 4] = op; req_funct[4*i +: 4] = fn;
  endtask

  task automatic push(input logic [1:0] v, input logic [31:0] r, input logic [3:0] s, input logic [3:0] e);
    rsp_t t;
    t.v = v; t.r = r; t.s = s; t.e = e;
    sb_q.push_back(t);
  endtask

  task automatic sb_check();
    rsp_t t;
    @(negedge clk);
    if (rsp_valid !== 2'b00) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: rsp_valid=%b, nothing pending", rsp_valid);
      end else begin
        t = sb_q.pop_front();
        if (rsp_valid !== t.v || rsp_result !== t.r || rsp_stat !== t.s || rsp_stat_en !== t.e) begin
          n_err++;
          $display("FAIL rsp_compare: got v=%b r=%h s=%b e=%b want v=%b r=%h s=%b e=%b",
                   rsp_valid, rsp_result, rsp_stat, rsp_stat_en, t.v, t.r, t.s, t.e);
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    clr_reqs();
    for (int k = 0; k < 8; k++) begin
      if (sb_q.size() == 0) break;
      sb_check();
      next_cycle();
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d responses still pending, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    clr_reqs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clr_reqs();
    rst = 1'b1;
    drive(0, 1'b0, 32'd10, 32'd1, OP_S, FN_ADD, 1'b0);
    drive(1, 1'b0, 32'd20, 32'd2, OP_S, FN_ADD, 1'b0);
    next_cycle();
    sb_check();
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_vec++; if (alu_op !== IDLE || alu_funct !== 4'd0) begin n_err++; $display("FAIL reset_ctl: got op=%b funct=%b want 1100/0000", alu_op, alu_funct); end
    n_vec++; if (alu_rsa !== 32'd0 || alu_rsb !== 32'd0 || alu_imm !== 16'd0 || alu_c_in !== 1'b0) begin
      n_err++; $display("FAIL reset_operands: got rsa=%h rsb=%h imm=%h c=%b want zeros", alu_rsa, alu_rsb, alu_imm, alu_c_in); end
    n_vec++; if (rsp_valid !== 2'b00 || rsp_stat !== 4'd0 || rsp_stat_en !== 4'd0) begin
      n_err++; $display("FAIL reset_rsp: got v=%b s=%b e=%b want 0", rsp_valid, rsp_stat, rsp_stat_en); end
    next_cycle();
    rst = 1'b0;
    push(2'b01, 32'd11, 4'b0000, 4'b1111);
    sb_check();
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL reset_first_tie: got %b want 01", req_ready); end
    next_cycle();
    drain();
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 1'b0, 32'd5, 32'd7, OP_S, FN_ADD, 1'b0);
    push(2'b01, 32'd12, 4'b0000, 4'b1111);
    sb_check();
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b want 01", req_ready); end
    next_cycle();
    clr_reqs();
    sb_check();
    n_vec++; if (alu_rsa !== 32'd5 || alu_rsb !== 32'd7 || alu_op !== OP_S || alu_funct !== FN_ADD) begin
      n_err++; $display("FAIL single_issue: got rsa=%h rsb=%h op=%b fn=%b want 5/7/0001/0001", alu_rsa, alu_rsb, alu_op, alu_funct); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_early: got %b want 00", rsp_valid); end
    next_cycle();
    sb_check();
    n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL single_latency: got %b want 01", rsp_valid); end
    next_cycle();
    drain();
  endtask

  task automatic test_tie();
    logic [1:0] exp;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      clr_reqs();
      if (k < 4) begin
        drive(0, 1'b0, 32'd10 + k, 32'd1, OP_S, FN_ADD, 1'b0);
        drive(1, 1'b0, 32'd20 + k, 32'd2, OP_S, FN_ADD, 1'b0);
        if (k % 2 == 0) push(2'b01, 32'd11 + k, 4'b0000, 4'b1111);
        else            push(2'b10, 32'd22 + k, 4'b0000, 4'b1111);
      end
      sb_check();
      if (k < 4) begin
        exp = (k % 2 == 0) ? 2'b01 : 2'b10;
        n_vec++; if (req_ready !== exp) begin n_err++; $display("FAIL tie_ready[%0d]: got %b want %b", k, req_ready, exp); end
      end
      if (k >= 2) begin
        exp = (k % 2 == 0) ? 2'b01 : 2'b10;
        n_vec++; if (rsp_valid !== exp) begin n_err++; $display("FAIL tie_strobe[%0d]: got %b want %b", k, rsp_valid, exp); end
      end
      next_cycle();
    end
    drain();
  endtask

  task automatic test_lock();
    do_reset();
    drive(1, 1'b1, 32'd3, 32'd3, OP_S, FN_SUB, 1'b0);
    push(2'b10, 32'd0, 4'b1001, 4'b1111);
    sb_check();
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL lock_take: got %b want 10", req_ready); end
    next_cycle();
    clr_reqs();
    drive(0, 1'b0, 32'd1, 32'd1, OP_S, FN_ADD, 1'b0);
    sb_check();
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL lock_owner_idle: got %b want 00", req_ready); end
    next_cycle();
    drive(1, 1'b0, 32'd4, 32'd5, OP_S, FN_ADD, 1'b0);
    push(2'b10, 32'd9, 4'b0000, 4'b1111);
    sb_check();
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL lock_release: got %b want 10", req_ready); end
    next_cycle();
    clr_reqs();
    drive(0, 1'b0, 32'd1, 32'd1, OP_S, FN_ADD, 1'b0);
    push(2'b01, 32'd2, 4'b0000, 4'b1111);
    sb_check();
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL lock_after: got %b want 01", req_ready); end
    next_cycle();
    drain();
  endtask

  task automatic test_idle();
    do_reset();
    drive(0, 1'b0, 32'h55, 32'd0, OP_S, FN_ADD, 1'b0);
    push(2'b01, 32'h55, 4'b0000, 4'b1111);
    sb_check();
    next_cycle();
    for (int k = 1; k <= 5; k++) begin
      clr_reqs();
      sb_check();
      if (k >= 2 && k <= 4) begin
        n_vec++; if (alu_op !== IDLE || alu_funct !== 4'd0 || alu_rsa !== 32'h55) begin
          n_err++; $display("FAIL idle_issue[%0d]: got op=%b fn=%b rsa=%h want 1100/0000/55", k, alu_op, alu_funct, alu_rsa); end
      end
      if (k >= 3) begin
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL idle_rsp[%0d]: got %b want 00", k, rsp_valid); end
      end
      next_cycle();
    end
    drain();
  endtask

  task automatic test_overflow();
    drive(0, 1'b0, 32'h7FFFFFFF, 32'd1, OP_S, FN_ADD, 1'b0);
    push(2'b01, 32'h80000000, 4'b0110, 4'b1111);
    sb_check();
    next_cycle();
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, pa;
    logic [3:0]  op, fn;
    logic        ci, pci;
    logic [1:0]  exp;
    logic [39:0] r;
    pa = 32'd0; pci = 1'b0;
    for (int k = 0; k < 8; k++) begin
      clr_reqs();
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
      fn = (k % 3 == 0) ? FN_SUB : FN_ADD;
      op = (k % 4 < 2) ? OP_S : OP_N;
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      drive(k % 2, 1'b0, a, b, op, fn, ci);
      r = alu_ref(a, b, op, fn, ci);
      push(exp, r[31:0], r[35:32], r[39:36]);
      sb_check();
      n_vec++; if (req_ready !== exp) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, req_ready, exp); end
      if (k > 0) begin
        n_vec++; if (alu_imm !== pa[15:0] || alu_c_in !== pci) begin
          n_err++; $display("FAIL b2b_imm[%0d]: got imm=%h c=%b want %h/%b", k, alu_imm, alu_c_in, pa[15:0], pci); end
      end
      pa = a; pci = ci;
      next_cycle();
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(0, 1'b0, 32'd100, 32'd1, OP_S, FN_ADD, 1'b0);
    sb_check();
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_accept: got %b want 01", req_ready); end
    next_cycle();
    rst = 1'b1;
    drive(1, 1'b0, 32'd50, 32'd2, OP_S, FN_ADD, 1'b0);
    sb_check();
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL mid_rst_ready: got %b want 00", req_ready); end
    next_cycle();
    rst = 1'b0;
    push(2'b01, 32'd101, 4'b0000, 4'b1111);
    sb_check();
    n_vec++; if (alu_op !== IDLE || rsp_valid !== 2'b00) begin
      n_err++; $display("FAIL mid_flush: got op=%b v=%b want 1100/00", alu_op, rsp_valid); end
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_tie: got %b want 01", req_ready); end
    next_cycle();
    clr_reqs();
    sb_check();
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_quiet: got %b want 00", rsp_valid); end
    next_cycle();
    drain();
  endtask

  initial begin
    rst = 1'b1;
    clr_reqs();
    next_cycle();
    test_reset();
    test_single();
    test_tie();
    test_lock();
    test_idle();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
